// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
// Also holds the round-robin index helper used by rr_arbiter.
package uart_pkg;

    localparam int DEF_NUM_REQ      = 3;
    localparam int DEF_DATA_AMOUNT  = 8;
    localparam int DEF_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_arb_state_t;

    // Requester index reached by stepping 'step' places past 'last', wrapping at n.
    function automatic int rr_next(input int last, input int step, input int n);
        return (last + step) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches upward from the requester
// after the last winner, wrapping, and returns a one-hot grant.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // First requesting index after the previous winner gets the grant.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int step = 1; step <= NUM_REQ; step++) begin
            w_idx = IDX_W'(rr_next(int'(i_last_grant), step, NUM_REQ));
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between several byte requesters: round-robin
// acceptance, one-cycle launch pulse, and a timeout if the transmitter never goes busy.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_AMOUNT  = DEF_DATA_AMOUNT,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*DATA_AMOUNT-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic                           tx_ready_i,
    output logic                           tx_en_o,
    output logic [DATA_AMOUNT-1:0]         tx_data_o,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(BUSY_TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_RESET = IDX_W'(NUM_REQ - 1);

    tx_arb_state_t r_state;
    tx_arb_state_t w_state_nxt;

    logic [IDX_W-1:0]       r_last_grant;
    logic [DATA_AMOUNT-1:0] r_tx_data;
    logic [NUM_REQ-1:0]     r_grant;
    logic                   r_tx_en;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;

    logic [NUM_REQ-1:0]     w_rr_grant;
    logic [IDX_W-1:0]       w_grant_idx;
    logic [DATA_AMOUNT-1:0] w_sel_data;
    logic                   w_accept;
    logic                   w_timeout;
    logic                   w_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req        (req_valid_i),
        .i_last_grant (r_last_grant),
        .o_grant      (w_rr_grant)
    );

    // One-hot winner folded into its index and its byte (AND-OR mux).
    always_comb begin
        w_grant_idx = '0;
        w_sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_grant_idx = w_grant_idx | (IDX_W'(k) & {IDX_W{w_rr_grant[k]}});
            w_sel_data  = w_sel_data
                        | (req_data_i[k*DATA_AMOUNT +: DATA_AMOUNT] & {DATA_AMOUNT{w_rr_grant[k]}});
        end
    end

    // Next-state logic and transfer events.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_ready_i && (|req_valid_i)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready_i) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_cnt >= CNT_LAST) begin
                    // Transmitter never took the byte: drop it, no retry.
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Accept strobe is combinational; masked during reset so no byte is taken and lost.
    always_comb begin
        if (w_accept && !rst_i) begin
            req_ready_o = w_rr_grant;
        end else begin
            req_ready_o = '0;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output, ownership and round-robin pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_en      <= 1'b0;
            r_err        <= 1'b0;
            r_tx_data    <= '0;
            r_grant      <= '0;
            r_last_grant <= IDX_RESET;
        end else begin
            r_tx_en <= w_accept;
            r_err   <= w_timeout;
            if (w_accept) begin
                r_tx_data    <= w_sel_data;
                r_grant      <= w_rr_grant;
                r_last_grant <= w_grant_idx;
            end else if (w_timeout || w_done) begin
                r_grant <= '0;
            end else begin
                r_grant <= r_grant;
            end
        end
    end

    // Saturating count of WAIT_BUSY cycles with the transmitter still ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_LOAD) begin
            r_cnt <= '0;
        end else if ((r_state == ST_WAIT_BUSY) && tx_ready_i && (r_cnt != CNT_SAT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign tx_en_o   = r_tx_en;
    assign tx_data_o = r_tx_data;
    assign grant_o   = r_grant;
    assign err_o     = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic against a cycle-level reference model and a simple transceiver model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 8;
    localparam int TMO  = 16;
    localparam int RBUF = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_ready;
    logic                 tx_en;
    logic [DW-1:0]        tx_data;
    logic [NREQ-1:0]      grant;
    logic                 err;

    // transceiver model (or a forced ready level)
    logic force_en;
    logic force_val;
    logic model_no_drop;
    logic model_ready = 1'b1;
    int   busy_cnt = 0;

    assign tx_ready = force_en ? force_val : model_ready;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_AMOUNT(DW), .BUSY_TIMEOUT(TMO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .tx_ready_i  (tx_ready),
        .tx_en_o     (tx_en),
        .tx_data_o   (tx_data),
        .grant_o     (grant),
        .err_o       (err)
    );

    // Transceiver: on a launch it goes busy for a random length, occasionally ignores it.
    always @(posedge clk) begin
        if (model_ready) begin
            if (tx_en && !force_en && (model_no_drop || ($urandom_range(0, 9) != 0))) begin
                model_ready <= 1'b0;
                busy_cnt    <= int'($urandom_range(0, 5));
            end
        end else if (busy_cnt == 0) begin
            model_ready <= 1'b1;
        end else begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    int n_checks = 0;
    int n_errs   = 0;

    // reference model state
    logic          m_busy;
    int            m_age;
    logic          m_low;
    int            m_hi;
    int            m_owner;
    int            m_last;
    logic [DW-1:0] m_data;
    logic          m_err;

    logic [NREQ-1:0] snap_ready;
    logic [NREQ-1:0] snap_grant;
    logic            snap_en;
    logic            snap_err;
    logic [DW-1:0]   snap_data;
    logic            acc_flag;
    int              acc_idx;

    logic [DW-1:0] rbuf [NREQ][RBUF];
    int            rhead [NREQ];
    int            rtail [NREQ];
    int            total_push;
    int            total_acc;

    logic [DW-1:0] fair_seq [4];
    logic [DW-1:0] fair_exp [4] = '{8'h10, 8'h20, 8'h30, 8'h10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_age   = 0;
        m_low   = 1'b0;
        m_hi    = 0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_data  = '0;
        m_err   = 1'b0;
    endtask

    // One clock: check DUT outputs against the model, advance the model, move to next negedge.
    task automatic cycle();
        int win;
        int k;
        logic [31:0] exp_rr;
        logic [31:0] exp_en;
        logic [31:0] exp_gr;
        #1;
        snap_ready = req_ready;
        snap_en    = tx_en;
        snap_data  = tx_data;
        snap_grant = grant;
        snap_err   = err;
        win = -1;
        if (!rst && !m_busy && tx_ready && (req_valid != '0)) begin
            for (int s = 1; s <= NREQ; s++) begin
                k = (m_last + s) % NREQ;
                if (win < 0 && req_valid[k]) win = k;
            end
        end
        exp_rr = (win >= 0) ? (32'd1 << win) : 32'd0;
        exp_en = (m_busy && m_age == 1) ? 32'd1 : 32'd0;
        exp_gr = m_busy ? (32'd1 << m_owner) : 32'd0;
        check("req_ready", 32'(snap_ready), exp_rr);
        check("tx_en", 32'(snap_en), exp_en);
        check("grant", 32'(snap_grant), exp_gr);
        check("tx_data", 32'(snap_data), 32'(m_data));
        check("err", 32'(snap_err), 32'(m_err));
        acc_flag = 1'b0;
        m_err    = 1'b0;
        if (rst) begin
            model_reset();
        end else if (win >= 0) begin
            acc_flag = 1'b1;
            acc_idx  = win;
            m_busy   = 1'b1;
            m_age    = 1;
            m_owner  = win;
            m_last   = win;
            m_low    = 1'b0;
            m_hi     = 0;
            m_data   = req_data[win*DW +: DW];
        end else if (m_busy) begin
            if (m_age == 1) begin
                m_age = 2;
            end else if (!m_low) begin
                if (!tx_ready) begin
                    m_low = 1'b1;
                end else begin
                    m_hi++;
                    if (m_hi == TMO) begin
                        m_busy = 1'b0;
                        m_err  = 1'b1;
                    end
                end
            end else if (tx_ready) begin
                m_busy = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Drive ready through LOAD, one busy cycle, then done.
    task automatic complete_forced();
        force_val = 1'b1;
        cycle();
        force_val = 1'b0;
        cycle();
        force_val = 1'b1;
        cycle();
    endtask

    // Present each requester's queue head, optionally with random valid gaps.
    task automatic drive_queues(input logic gaps);
        logic pend;
        for (int k = 0; k < NREQ; k++) begin
            pend = (rhead[k] < rtail[k]);
            req_valid[k] = pend && (!gaps || ($urandom_range(0, 3) != 0));
            req_data[k*DW +: DW] = pend ? rbuf[k][rhead[k]] : DW'($urandom);
        end
    endtask

    initial begin
        int n_en;
        int n_pulse;
        int budget;
        int pending;

        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        force_en = 1'b1;
        force_val = 1'b1;
        model_no_drop = 1'b1;
        total_push = 0;
        total_acc = 0;
        for (int k = 0; k < NREQ; k++) begin
            rhead[k] = 0;
            rtail[k] = 0;
        end
        model_reset();
        @(negedge clk);

        // reset state, accept strobe masked while reset is high
        req_valid = 3'b111;
        cycle();
        check("rst_ready", 32'(snap_ready), 32'd0);
        check("rst_en", 32'(snap_en), 32'd0);
        check("rst_grant", 32'(snap_grant), 32'd0);
        check("rst_data", 32'(snap_data), 32'd0);
        check("rst_err", 32'(snap_err), 32'd0);
        rst = 1'b0;
        req_valid = '0;
        cycle();

        // single request
        req_valid = 3'b001;
        req_data[0 +: DW] = 8'h41;
        cycle();
        check("single_ready", 32'(snap_ready), 32'd1);
        req_valid = '0;
        cycle();
        check("single_en", 32'(snap_en), 32'd1);
        check("single_data", 32'(snap_data), 32'h41);
        check("single_grant", 32'(snap_grant), 32'd1);
        force_val = 1'b0;
        cycle();
        cycle();
        check("single_grant_busy", 32'(snap_grant), 32'd1);
        force_val = 1'b1;
        cycle();
        cycle();
        check("single_grant_clr", 32'(snap_grant), 32'd0);
        check("single_data_hold", 32'(snap_data), 32'h41);

        // fairness with all requesters valid
        do_reset();
        force_en = 1'b0;
        req_data = {8'h30, 8'h20, 8'h10};
        req_valid = 3'b111;
        for (int i = 0; i < 4; i++) fair_seq[i] = '0;
        n_en = 0;
        n_pulse = 0;
        budget = 0;
        while (n_en < 4 && budget < 100) begin
            cycle();
            budget++;
            if (snap_ready != '0) n_pulse++;
            if (snap_en) begin
                fair_seq[n_en] = snap_data;
                n_en++;
            end
        end
        req_valid = '0;
        check("fair_budget", 32'(n_en), 32'd4);
        for (int i = 0; i < 4; i++) check("fair_seq", 32'(fair_seq[i]), 32'(fair_exp[i]));
        check("fair_pulses", 32'(n_pulse), 32'd4);
        repeat (15) cycle();

        // busy transceiver holds off acceptance
        force_en = 1'b1;
        force_val = 1'b0;
        req_valid = 3'b010;
        req_data[DW +: DW] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("busy_hold", 32'(snap_ready), 32'd0);
        end
        force_val = 1'b1;
        cycle();
        check("busy_accept", 32'(snap_ready), 32'b010);
        req_valid = '0;
        complete_forced();
        cycle();

        // timeout: transceiver never goes busy
        force_val = 1'b1;
        req_valid = 3'b001;
        req_data[0 +: DW] = 8'h77;
        cycle();
        check("to_accept", 32'(snap_ready), 32'd1);
        req_valid = '0;
        for (int i = 0; i < 17; i++) begin
            cycle();
            check("to_err_low", 32'(snap_err), 32'd0);
            check("to_grant_held", 32'(snap_grant), 32'd1);
        end
        cycle();
        check("to_err_pulse", 32'(snap_err), 32'd1);
        check("to_grant_clr", 32'(snap_grant), 32'd0);
        cycle();
        check("to_err_end", 32'(snap_err), 32'd0);

        // reset while waiting for the transfer to finish
        do_reset();
        force_val = 1'b1;
        req_valid = 3'b010;
        req_data[DW +: DW] = 8'h66;
        cycle();
        check("wd_accept", 32'(snap_ready), 32'b010);
        req_valid = '0;
        cycle();
        force_val = 1'b0;
        cycle();
        cycle();
        req_valid = 3'b011;
        req_data[0 +: DW] = 8'h33;
        req_data[DW +: DW] = 8'h44;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("wd_rst_en", 32'(snap_en), 32'd0);
        check("wd_rst_grant", 32'(snap_grant), 32'd0);
        check("wd_rst_data", 32'(snap_data), 32'd0);
        check("wd_rst_err", 32'(snap_err), 32'd0);
        check("wd_rst_wait", 32'(snap_ready), 32'd0);
        force_val = 1'b1;
        cycle();
        check("wd_first_req0", 32'(snap_ready), 32'b001);
        req_valid = 3'b010;
        complete_forced();
        cycle();
        check("wd_then_req1", 32'(snap_ready), 32'b010);
        req_valid = '0;
        complete_forced();

        // wrap from requester 2 back to 0
        do_reset();
        force_val = 1'b1;
        req_valid = 3'b100;
        req_data[2*DW +: DW] = 8'h22;
        cycle();
        check("wrap_pre", 32'(snap_ready), 32'b100);
        req_valid = '0;
        complete_forced();
        req_valid = 3'b011;
        req_data[0 +: DW] = 8'hA0;
        req_data[DW +: DW] = 8'hB1;
        cycle();
        check("wrap_first", 32'(snap_ready), 32'b001);
        req_valid = 3'b010;
        complete_forced();
        cycle();
        check("wrap_second", 32'(snap_ready), 32'b010);
        req_valid = '0;
        complete_forced();

        // randomized traffic against the model transceiver
        force_en = 1'b0;
        model_no_drop = 1'b0;
        repeat (3) cycle();
        for (int c = 0; c < 1000; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (rtail[k] < RBUF && $urandom_range(0, 7) == 0) begin
                    rbuf[k][rtail[k]] = DW'($urandom);
                    rtail[k]++;
                    total_push++;
                end
            end
            drive_queues(1'b1);
            cycle();
            if (acc_flag) begin
                rhead[acc_idx]++;
                total_acc++;
            end
        end

        // drain everything still queued
        budget = 0;
        pending = 0;
        for (int k = 0; k < NREQ; k++) pending += rtail[k] - rhead[k];
        while ((pending != 0 || m_busy) && budget < 4000) begin
            drive_queues(1'b0);
            cycle();
            budget++;
            if (acc_flag) begin
                rhead[acc_idx]++;
                total_acc++;
            end
            pending = 0;
            for (int k = 0; k < NREQ; k++) pending += rtail[k] - rhead[k];
        end
        check("drain_done", 32'(pending), 32'd0);
        check("no_loss", 32'(total_acc), 32'(total_push));
        req_valid = '0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of requesters sharing one uart_transceiver (range 2..8).
REQ-002 The block SHALL have parameter DATA_AMOUNT, default 8, giving the byte width.
REQ-003 The block SHALL have parameter BUSY_TIMEOUT, default 16, giving the max cycles to wait for tx_ready_i to fall after a launch.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-005 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid_i, input, NUM_REQ bits: per-requester byte valid.
REQ-007 The block SHALL have port req_data_i, input, NUM_REQ*DATA_AMOUNT bits: per-requester byte, requester k at slice [k*DATA_AMOUNT +: DATA_AMOUNT].
REQ-008 The block SHALL have port req_ready_o, output, NUM_REQ bits: one-hot accept strobe.
REQ-009 The block SHALL have port tx_ready_i, input, 1 bit: ready_o of the transceiver.
REQ-010 The block SHALL have port tx_en_o, output, 1 bit: launch pulse to the transceiver en_i.
REQ-011 The block SHALL have port tx_data_o, output, DATA_AMOUNT bits: byte to the transceiver data_i.
REQ-012 The block SHALL have port grant_o, output, NUM_REQ bits: one-hot owner of the current transfer, zero when idle.
REQ-013 The block SHALL have port err_o, output, 1 bit: one-cycle timeout pulse.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE with tx_ready_i=1 and any req_valid_i set, the block SHALL select a winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-016 In that same cycle, req_ready_o SHALL be high for the winner only, combinationally; the winner's data is registered into tx_data_o and grant_o; last_grant is updated; the FSM moves to LOAD.
REQ-017 In IDLE with tx_ready_i=0, req_ready_o SHALL be all-zero and no selection is made.
REQ-018 In LOAD, tx_en_o SHALL be high for exactly one cycle, the cycle after acceptance, and the FSM moves to WAIT_BUSY.
REQ-019 In WAIT_BUSY, the block SHALL move to WAIT_DONE when tx_ready_i=0.
REQ-020 In WAIT_BUSY, if tx_ready_i stays 1 for BUSY_TIMEOUT cycles, err_o SHALL pulse one cycle, the FSM SHALL return to IDLE, grant_o SHALL clear, and the byte is dropped with no retry.
REQ-021 In WAIT_DONE, the block SHALL move to IDLE when tx_ready_i=1 and clear grant_o in the same transition.
REQ-022 The minimum spacing between acceptances SHALL be 4 cycles.
REQ-023 tx_data_o SHALL hold the accepted byte from LOAD until the next acceptance.
REQ-024 A requester SHALL hold valid and data stable until its req_ready_o; retracting valid before acceptance is allowed and simply removes it from arbitration.
REQ-025 A valid that rises while not IDLE SHALL wait with no loss.
REQ-026 With all requesters continuously valid, grants SHALL rotate 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ transfers.
REQ-027 The timeout counter SHALL be $clog2(BUSY_TIMEOUT+1) bits, cleared on LOAD, and saturating.
REQ-028 tx_en_o, tx_data_o, grant_o and err_o SHALL be registered outputs.

Reset
REQ-029 On rst_i=1 at a clock edge, the block SHALL go to IDLE with tx_en_o=0, tx_data_o=0, grant_o=0, err_o=0, req_ready_o=0, last_grant=NUM_REQ-1 (requester 0 first), and the timeout counter at 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer without asserting tx_en_o; the transceiver is not reset by this block, and after reset the block waits for tx_ready_i=1 before accepting.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum type tx_arb_state_t and the default constants (NUM_REQ, BUSY_TIMEOUT).
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last_grant; output one-hot grant; combinational).
REQ-033 The FSM, the timeout counter and the data register SHALL live in uart_tx_arbiter.

Verification
REQ-034 Single request: req_valid_i=001, data0=0x41, tx_ready_i model idle -> req_ready_o=001 at T, tx_en_o=1 at T+1, tx_data_o=0x41, grant_o=001 until ready returns.
REQ-035 Fairness: all three valid continuously with data 0x10/0x20/0x30 -> tx_data_o sequence 0x10,0x20,0x30,0x10, exactly one req_ready_o pulse per transfer.
REQ-036 Busy transceiver: tx_ready_i=0, req_valid_i=010 -> req_ready_o stays 0; on tx_ready_i rise -> accept requester 1 in that cycle.
REQ-037 Timeout: tx_ready_i held 1 after LOAD -> err_o pulses after exactly 16 WAIT_BUSY cycles, FSM in IDLE, grant_o=0.
REQ-038 Reset in WAIT_DONE: assert rst_i one cycle -> all outputs 0 next cycle; a pending request from requester 0 is accepted first once tx_ready_i=1.
REQ-039 Wrap: last grant=2, req_valid_i=011 -> requester 0 granted before requester 1.
